// File: rtl/decoder_n_seq.sv
// N-to-2**N one-hot decoder with registered output: handshake load mode and timed auto-scan mode.
// Optional parity check on loaded codes is enabled with `define DECODE_PARITY_EN.
module decoder_n_seq #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        code_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                scan_en,
    input  logic                enable,
    output logic [(2**N)-1:0]   code_out,
    output logic                out_valid,
    output logic [N-1:0]        cur_code,
    output logic                scan_wrap
`ifdef DECODE_PARITY_EN
    ,
    input  logic                parity_in,
    output logic                parity_err
`endif
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned DW = $clog2(DWELL) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCAN} state_t;

    state_t          state, nxt_state;
    logic [DW-1:0]   dwell, nxt_dwell;
    logic [N-1:0]    nxt_code;
    logic            nxt_wrap;
    logic            parity_ok;
    logic            handshake;
    logic            transfer;
    logic            live;

    assign in_ready  = !scan_en;
    assign handshake = in_valid & in_ready;

`ifdef DECODE_PARITY_EN
    assign parity_ok = ~^{code_in, parity_in};
`else
    assign parity_ok = 1'b1;
`endif

    assign transfer = handshake & parity_ok;

    // Next-state selection; scan_en outranks any load request.
    always_comb begin
        nxt_state = state;
        nxt_code  = cur_code;
        nxt_dwell = dwell;
        nxt_wrap  = 1'b0;
        if (scan_en) begin
            if (state != S_SCAN) begin
                nxt_state = S_SCAN;
                nxt_code  = '0;
                nxt_dwell = '0;
            end else if (dwell == DW'(DWELL - 1)) begin
                nxt_dwell = '0;
                nxt_code  = cur_code + N'(1);
                nxt_wrap  = (cur_code == N'(W - 1));
            end else begin
                nxt_dwell = dwell + DW'(1);
            end
        end else if (transfer) begin
            nxt_state = S_HOLD;
            nxt_code  = code_in;
            nxt_dwell = '0;
        end else if (state == S_SCAN) begin
            nxt_state = S_HOLD;
            nxt_dwell = '0;
        end
    end

    // Outputs track the state being entered so code_out is valid with 1-cycle latency.
    assign live = enable && (nxt_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell     <= '0;
            cur_code  <= '0;
            code_out  <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state     <= nxt_state;
            dwell     <= nxt_dwell;
            cur_code  <= nxt_code;
            scan_wrap <= nxt_wrap;
            code_out  <= live ? (W'(1) << nxt_code) : '0;
            out_valid <= live;
        end
    end

`ifdef DECODE_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= handshake & ~parity_ok;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_n_seq.sv
// Scoreboard bench for decoder_n_seq: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares one entry per clock.
module tb_decoder_n_seq;

    localparam int N     = 2;
    localparam int DWELL = 3;
    localparam int W     = 2 ** N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   code_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           scan_en = 1'b0;
    logic           enable = 1'b0;
    logic [W-1:0]   code_out;
    logic           out_valid;
    logic [N-1:0]   cur_code;
    logic           scan_wrap;
    logic           p_bad = 1'b0;
`ifdef DECODE_PARITY_EN
    logic           parity_in = 1'b0;
    logic           parity_err;
`endif

    decoder_n_seq #(.N(N), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scan_en   (scan_en),
        .enable    (enable),
        .code_out  (code_out),
        .out_valid (out_valid),
        .cur_code  (cur_code),
        .scan_wrap (scan_wrap)
`ifdef DECODE_PARITY_EN
        ,
        .parity_in (parity_in),
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] co;
        logic         ov;
        logic [N-1:0] cc;
        logic         wr;
        logic         rdy;
        logic         pe;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: mode 0 = nothing loaded, 1 = holding, 2 = scanning; t counts cycles since scan entry.
    int   m_mode = 0;
    int   m_sel  = 0;
    int   m_t    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_sel  = 0;
        m_t    = 0;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected response.
    task automatic cyc(input logic r, input logic s, input logic v, input int c, input logic e);
        exp_t x;
        bit   accept;
        @(negedge clk);
        rst      = r;
        scan_en  = s;
        in_valid = v;
        code_in  = N'(c);
        enable   = e;
`ifdef DECODE_PARITY_EN
        parity_in = (^code_in) ^ p_bad;
        accept    = v && !s && !p_bad;
`else
        accept    = v && !s;
`endif
        x.wr = 1'b0;
        x.pe = 1'b0;
        if (r) begin
            model_reset();
        end else if (s) begin
            if (m_mode != 2) begin
                m_mode = 2;
                m_t    = 0;
            end else begin
                m_t++;
                x.wr = (m_t % (DWELL * W)) == 0;
            end
            m_sel = (m_t / DWELL) % W;
        end else begin
            if (accept) begin
                m_sel  = c % W;
                m_mode = 1;
            end else if (m_mode == 2) begin
                m_mode = 1;
            end
            x.pe = v && !accept;
        end
        x.co  = (e && !r && m_mode != 0) ? W'(1) << m_sel : '0;
        x.ov  = (x.co != '0);
        x.cc  = N'(m_sel);
        x.rdy = !s;
        exp_q.push_back(x);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_code_out", 32'(code_out), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cur_code", 32'(cur_code), 32'd0);
        chk("async_rst_scan_wrap", 32'(scan_wrap), 32'd0);
        model_reset();
    endtask

    // Monitor: every cycle with an expectation pending, compare the full output set.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("code_out", 32'(code_out), 32'(x.co));
                chk("out_valid", 32'(out_valid), 32'(x.ov));
                chk("cur_code", 32'(cur_code), 32'(x.cc));
                chk("scan_wrap", 32'(scan_wrap), 32'(x.wr));
                chk("in_ready", 32'(in_ready), 32'(x.rdy));
`ifdef DECODE_PARITY_EN
                chk("parity_err", 32'(parity_err), 32'(x.pe));
`endif
            end
        end
    end

    initial begin
        bit s_rand;
        int waited;
        // Reset, then idle with nothing loaded.
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Loads, including back-to-back.
        cyc(0, 0, 1, 2, 1);
        cyc(0, 0, 1, 3, 1);
        cyc(0, 0, 0, 0, 1);
        // Full scan lap plus wrap.
        repeat (14) cyc(0, 1, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // scan_en and in_valid together; leave scan at 0100.
        cyc(0, 1, 1, 3, 1);
        repeat (6) cyc(0, 1, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // Blanking in HOLD and restore.
        cyc(0, 0, 1, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        // Blanked scan keeps advancing.
        repeat (5) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 1);
`ifdef DECODE_PARITY_EN
        cyc(0, 0, 0, 0, 1);
        p_bad = 1'b1;
        cyc(0, 0, 1, 1, 1);
        p_bad = 1'b0;
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
`endif
        // Asynchronous reset mid-scan with a pending transfer, then accept on first edge.
        repeat (4) cyc(0, 1, 1, 2, 1);
        async_reset_check();
        repeat (2) cyc(1, 0, 1, 2, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        // Randomised traffic.
        s_rand = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) s_rand = ~s_rand;
`ifdef DECODE_PARITY_EN
            p_bad = ($urandom_range(0, 7) == 0);
`endif
            cyc(($urandom_range(0, 63) == 0), s_rand, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, W - 1)), ($urandom_range(0, 9) != 0));
        end
        p_bad = 1'b0;
        cyc(0, 0, 0, 0, 1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
